// File: rtl/ha_pkg.sv
// Shared types and constants for the registered half-adder bank.
package ha_pkg;

  localparam int HA_DEFAULT_WIDTH = 1;

  // One lane's result; {carry, sum} reads directly as the 2-bit value a+b.
  typedef struct packed {
    logic carry;
    logic sum;
  } ha_res_t;

  // Reference half add for one lane, returned in result-struct form.
  function automatic ha_res_t ha_add(input logic a, input logic b);
    ha_res_t r;
    r.sum   = a ^ b;
    r.carry = a & b;
    return r;
  endfunction

endpackage

// File: rtl/ha_lane.sv
// Combinational 1-bit half adder: one lane of the ha_v1 bank.
module ha_lane
  import ha_pkg::*;
(
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b
);

  ha_res_t res;

  // Lane function; the packed result keeps {carry,sum} == a+b by construction.
  always_comb begin
    res   = ha_add(a, b);
    sum   = res.sum;
    carry = res.carry;
  end

endmodule

// File: rtl/ha_v1.sv
// Registered half-adder bank: WIDTH independent lanes, one-cycle latency,
// valid flag and registered OR-reduction of the carries.
// Optional build macro HA_V1_COMB_OUT_EN adds zero-latency sum_comb/carry_comb
// outputs that bypass the register, in_valid and rst.
module ha_v1
  import ha_pkg::*;
#(
  parameter int WIDTH         = HA_DEFAULT_WIDTH,
  parameter bit RESET_OUTPUTS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             out_valid,
  output logic             carry_any
`ifdef HA_V1_COMB_OUT_EN
  ,
  output logic [WIDTH-1:0] sum_comb,
  output logic [WIDTH-1:0] carry_comb
`endif
);

  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] carry_nxt;
  ha_res_t [WIDTH-1:0] res_q;
  logic carry_any_q;
  logic vld_q;

  // One combinational half adder per lane; no inter-lane carry.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_lane u_lane (
      .sum   (sum_nxt[i]),
      .carry (carry_nxt[i]),
      .a     (a[i]),
      .b     (b[i])
    );
  end

  // Valid flag: reset wins over in_valid, idle cycles drop it.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= in_valid;
  end

  // Result register: loads only on accepted inputs so idle (possibly X)
  // operands never reach the outputs; optionally cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_OUTPUTS) begin
        res_q       <= '0;
        carry_any_q <= 1'b0;
      end
    end else if (in_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        res_q[i].sum   <= sum_nxt[i];
        res_q[i].carry <= carry_nxt[i];
      end
      carry_any_q <= |carry_nxt;
    end
  end

  // Unpack the per-lane result structs onto the flat output buses.
  always_comb begin
    sum   = '0;
    carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = res_q[i].sum;
      carry[i] = res_q[i].carry;
    end
  end

  assign out_valid = vld_q;
  assign carry_any = carry_any_q;

`ifdef HA_V1_COMB_OUT_EN
  // Raw lane outputs, ungated by in_valid or rst.
  assign sum_comb   = sum_nxt;
  assign carry_comb = carry_nxt;
`endif

endmodule

// File: tb/tb_ha_v1.sv
// Directed self-checking bench for ha_v1 (8 lanes, outputs cleared on reset).
module tb_ha_v1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sum, carry, a, b;
  logic         in_valid, out_valid, carry_any;
`ifdef HA_V1_COMB_OUT_EN
  logic [W-1:0] sum_comb, carry_comb;
`endif

  int vectors = 0;
  int miscompares = 0;

  ha_v1 #(.WIDTH(W), .RESET_OUTPUTS(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum       (sum),
    .carry     (carry),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .carry_any (carry_any)
`ifdef HA_V1_COMB_OUT_EN
    ,
    .sum_comb  (sum_comb),
    .carry_comb(carry_comb)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    tick(); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    vectors++; if (sum !== 8'h00) begin miscompares++; $display("FAIL reset sum got=%h exp=00", sum); end
    vectors++; if (carry !== 8'h00) begin miscompares++; $display("FAIL reset carry got=%h exp=00", carry); end
    vectors++; if (carry_any !== 1'b0) begin miscompares++; $display("FAIL reset carry_any got=%b exp=0", carry_any); end
    rst = 1'b0;
  endtask

  // Classic 1-bit half adder on lane 0, all four rows back-to-back.
  task automatic test_truth_table();
    logic [1:0] ab [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       es [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       ec [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      a = {7'd0, ab[k][1]};
      b = {7'd0, ab[k][0]};
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL tt%0d out_valid got=%b exp=1", k, out_valid); end
      vectors++; if (sum !== {7'd0, es[k]}) begin miscompares++; $display("FAIL tt%0d sum got=%h exp=%h", k, sum, {7'd0, es[k]}); end
      vectors++; if (carry !== {7'd0, ec[k]}) begin miscompares++; $display("FAIL tt%0d carry got=%h exp=%h", k, carry, {7'd0, ec[k]}); end
      vectors++; if (carry_any !== ec[k]) begin miscompares++; $display("FAIL tt%0d carry_any got=%b exp=%b", k, carry_any, ec[k]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wide_vectors();
    in_valid = 1'b1; a = 8'hF0; b = 8'h3C;
    tick();
    vectors++; if (sum !== 8'hCC) begin miscompares++; $display("FAIL wide1 sum got=%h exp=cc", sum); end
    vectors++; if (carry !== 8'h30) begin miscompares++; $display("FAIL wide1 carry got=%h exp=30", carry); end
    vectors++; if (carry_any !== 1'b1) begin miscompares++; $display("FAIL wide1 carry_any got=%b exp=1", carry_any); end
    a = 8'h0F; b = 8'hF0;
    tick();
    vectors++; if (sum !== 8'hFF) begin miscompares++; $display("FAIL wide2 sum got=%h exp=ff", sum); end
    vectors++; if (carry !== 8'h00) begin miscompares++; $display("FAIL wide2 carry got=%h exp=00", carry); end
    vectors++; if (carry_any !== 1'b0) begin miscompares++; $display("FAIL wide2 carry_any got=%b exp=0", carry_any); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL wide2 out_valid got=%b exp=1", out_valid); end
    in_valid = 1'b0;
  endtask

  // Result must hold while idle, including with X on the operands.
  task automatic test_idle_hold();
    in_valid = 1'b1; a = 8'hF0; b = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin a = 'x; b = 'x; end
      else begin a = 8'($urandom); b = 8'($urandom); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL idle%0d out_valid got=%b exp=0", k, out_valid); end
      vectors++; if (sum !== 8'hCC) begin miscompares++; $display("FAIL idle%0d sum got=%h exp=cc", k, sum); end
      vectors++; if (carry !== 8'h30) begin miscompares++; $display("FAIL idle%0d carry got=%h exp=30", k, carry); end
      vectors++; if (carry_any !== 1'b1) begin miscompares++; $display("FAIL idle%0d carry_any got=%b exp=1", k, carry_any); end
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h01;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstpri out_valid got=%b exp=0", out_valid); end
    vectors++; if (carry !== 8'h00) begin miscompares++; $display("FAIL rstpri carry got=%h exp=00", carry); end
    vectors++; if (sum !== 8'h00) begin miscompares++; $display("FAIL rstpri sum got=%h exp=00", sum); end
    vectors++; if (carry_any !== 1'b0) begin miscompares++; $display("FAIL rstpri carry_any got=%b exp=0", carry_any); end
    rst = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rstrel out_valid got=%b exp=1", out_valid); end
    vectors++; if (carry !== 8'h01) begin miscompares++; $display("FAIL rstrel carry got=%h exp=01", carry); end
    vectors++; if (sum !== 8'h00) begin miscompares++; $display("FAIL rstrel sum got=%h exp=00", sum); end
    vectors++; if (carry_any !== 1'b1) begin miscompares++; $display("FAIL rstrel carry_any got=%b exp=1", carry_any); end
    in_valid = 1'b0;
    tick();
  endtask

  // All 256 4-bit a/b pairs streamed without gaps; the upper nibble carries
  // a swapped copy so every lane sees a different pattern.
  task automatic test_back_to_back();
    logic [3:0] a4, b4;
    logic [W-1:0] es, ec;
    logic [1:0] lane_sum;
    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i >> 4);
      b4 = 4'(i);
      a = {b4, a4};
      b = {a4, b4};
      in_valid = 1'b1;
      for (int j = 0; j < W; j++) begin
        lane_sum = 2'(a[j]) + 2'(b[j]);
        es[j] = lane_sum[0];
        ec[j] = lane_sum[1];
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || sum !== es || carry !== ec || carry_any !== (|ec)) begin
        miscompares++;
        $display("FAIL b2b%0d got v=%b s=%h c=%h any=%b exp v=1 s=%h c=%h any=%b",
                 i, out_valid, sum, carry, carry_any, es, ec, |ec);
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end out_valid got=%b exp=0", out_valid); end
  endtask

`ifdef HA_V1_COMB_OUT_EN
  task automatic test_comb_out();
    rst = 1'b1; in_valid = 1'b0; a = 8'h01; b = 8'h01;
    #1;
    vectors++; if (sum_comb !== 8'h00) begin miscompares++; $display("FAIL comb sum_comb got=%h exp=00", sum_comb); end
    vectors++; if (carry_comb !== 8'h01) begin miscompares++; $display("FAIL comb carry_comb got=%h exp=01", carry_comb); end
    a = 8'hF0; b = 8'h3C;
    #1;
    vectors++; if (sum_comb !== 8'hCC) begin miscompares++; $display("FAIL comb2 sum_comb got=%h exp=cc", sum_comb); end
    vectors++; if (carry_comb !== 8'h30) begin miscompares++; $display("FAIL comb2 carry_comb got=%h exp=30", carry_comb); end
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    test_reset();
    test_truth_table();
    test_wide_vectors();
    test_idle_hold();
    test_reset_priority();
    test_back_to_back();
`ifdef HA_V1_COMB_OUT_EN
    test_comb_out();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ha_v1.md
Name: ha_v1

Overview:
Registered half adder bank: per bit, sum = a XOR b and carry = a AND b across WIDTH independent lanes, with a one-cycle pipeline register and a valid flag.
Lowest-level arithmetic primitive for adder and counter datapaths; ripple and full adders are built by chaining instances.
At WIDTH=1 it is the classic 1-bit half adder.

Parameters:
WIDTH, 1, number of independent half-adder lanes (>=1)
RESET_OUTPUTS, 1, 1 = sum/carry cleared on rst; 0 = only out_valid cleared

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
sum  output  WIDTH  registered a XOR b per lane
carry  output  WIDTH  registered a AND b per lane
a  input  WIDTH  operand A
b  input  WIDTH  operand B
in_valid  input  1  a/b qualify this cycle
out_valid  output  1  sum/carry hold a valid result
carry_any  output  1  registered OR-reduction of carry

Positional order is clk, rst, sum, carry, a, b, in_valid, out_valid, carry_any.

Behaviour:
- Lane function, per bit i (the half-adder truth table):
  - a=0, b=0 -> sum=0, carry=0
  - a=0, b=1 -> sum=1, carry=0
  - a=1, b=0 -> sum=1, carry=0
  - a=1, b=1 -> sum=0, carry=1
- Lanes are fully independent; there is no carry propagation between lanes.
- Latency: exactly 1 clk. On the rising edge where in_valid=1, sum/carry/carry_any capture the function of a/b and out_valid becomes 1 on the next cycle.
- On an edge with in_valid=0:
  - out_valid becomes 0;
  - sum/carry/carry_any hold their last value (no toggling on idle cycles).
- Back-to-back in_valid: one result per cycle at full throughput; there is no backpressure input.
- Reset, synchronous, when rst=1 at a rising edge:
  - out_valid=0;
  - if RESET_OUTPUTS=1, also sum=0, carry=0, carry_any=0.
- rst has priority over in_valid on the same edge; an input presented with rst=1 is dropped.
- Reset mid-stream discards the in-flight result; the first valid output after release follows 1 cycle after the first accepted input.
- X on a or b while in_valid=0 must not propagate to the outputs.
- Width rule: the carry and sum of a lane together form the 2-bit value a[i]+b[i], that is {carry[i],sum[i]} = a[i]+b[i]. This must hold for every lane.

Optional Feature:
HA_V1_COMB_OUT_EN
- Defined: adds outputs sum_comb[WIDTH] and carry_comb[WIDTH]. These are the purely combinational a XOR b and a AND b, with zero latency, not gated by in_valid or rst.
- Undefined: those ports do not exist and only the registered path is present.
- The registered behaviour is identical in both builds.

Decomposition:
- Shared package ha_pkg:
  - constant HA_DEFAULT_WIDTH = 1;
  - typedef ha_res_t, a packed struct {carry, sum} for one lane.
- One natural sub-module: ha_lane, the combinational 1-bit half adder (sum, carry, a, b).
- The top generates WIDTH ha_lane instances and owns the output register, valid flag and carry_any reduction.

Test Plan:
- WIDTH=1, rst 2 cycles, then in_valid=1 applying a/b = 00, 01, 10, 11 on consecutive cycles -> one cycle later each: sum/carry = 0/0, 1/0, 1/0, 0/1; out_valid=1 on 4 consecutive cycles; carry_any=1 only for the 11 result.
- WIDTH=8, a=8'hF0, b=8'h3C, in_valid=1 -> next cycle sum=8'hCC, carry=8'h30, carry_any=1; a=8'h0F, b=8'hF0 -> sum=8'hFF, carry=8'h00, carry_any=0.
- Idle hold: result 8'hCC/8'h30, then in_valid=0 for 3 cycles with random a/b -> out_valid=0, sum/carry unchanged.
- Reset priority: rst=1 and in_valid=1 (a=1, b=1) on the same edge -> out_valid=0, carry=0 (RESET_OUTPUTS=1); on the next accepted 1+1 -> carry=1, sum=0.
- Exhaustive WIDTH=4: all 256 a/b pairs streamed back-to-back -> every lane satisfies {carry,sum}=a[i]+b[i], with 1-cycle latency.
- HA_V1_COMB_OUT_EN defined: a=1, b=1 with in_valid=0 and rst=1 -> sum_comb=0 and carry_comb=1 in the same cycle.
